// File: rtl/conv_window_buffer.sv
// conv_window_buffer
//   Turns a raster-order pixel stream into a stream of 3x3 windows. It uses two
//   line buffers that hold the previous two rows, plus a 3x3 shift window.
//   Only pixels with row >= 2 and col >= 2 produce a window, so a window never
//   straddles a row boundary.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-low reset
//   pix_valid   pixel on pix_data is accepted this cycle
//   pix_data    raster-order pixel, PIX_W bits
//   win_valid   win_data holds a complete window (1 cycle after the accept)
//   win_data    9 slots, slot k = 3*r+c at [k*PIX_W +: PIX_W]; r/c = 0 is oldest
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
//   win_row/win_col  (only with WIN_COORD_EN) top-left coordinate of the window
//
// Build option: define WIN_COORD_EN to add the win_row/win_col outputs.
module conv_window_buffer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_valid,
    input  logic [PIX_W-1:0]       pix_data,
    output logic                   win_valid,
    output logic [9*PIX_W-1:0]     win_data,
`ifdef WIN_COORD_EN
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
`endif
    output logic                   frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic {FILL, RUN} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              col_last, row_last;
    logic              win_valid_nxt, frame_done_nxt;

    // Line buffer 0 holds row-2, line buffer 1 holds row-1, both indexed by column.
    logic [PIX_W-1:0]  lb0 [IMG_W];
    logic [PIX_W-1:0]  lb1 [IMG_W];
    // win[r][c]: the packed layout flattens directly to the slot order 3*r+c.
    logic [2:0][2:0][PIX_W-1:0] win;
    logic [2:0][PIX_W-1:0]      new_col;

    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign new_col  = {pix_data, lb1[col], lb0[col]};
    assign win_data = win;

    // Next-state and next-output logic. RUN means row >= 2. In RUN, any accept
    // with col >= 2 completes a window.
    always_comb begin
        state_nxt      = state;
        win_valid_nxt  = 1'b0;
        frame_done_nxt = 1'b0;
        if (pix_valid) begin
            case (state)
                FILL: begin
                    if (row == RW'(1) && col_last)
                        state_nxt = RUN;
                end
                RUN: begin
                    if (col >= CW'(2))
                        win_valid_nxt = 1'b1;
                    if (row_last && col_last) begin
                        state_nxt      = FILL;
                        frame_done_nxt = 1'b1;
                    end
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FILL;
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            win_valid  <= win_valid_nxt;
            frame_done <= frame_done_nxt;
            if (pix_valid) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // The window shifts one column left on each accept. Reset clears only the
    // window. Line buffer contents are never qualified except through the counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win <= '0;
        end else if (pix_valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
                win[r][2] <= new_col[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && pix_valid) begin
            lb0[col] <= lb1[col];
            lb1[col] <= pix_data;
        end
    end

`ifdef WIN_COORD_EN
    // The top-left corner is two rows up and two columns left of the accepted pixel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_row <= '0;
            win_col <= '0;
        end else if (win_valid_nxt) begin
            win_row <= row - RW'(2);
            win_col <= col - CW'(2);
        end
    end
`endif

endmodule

// File: doc/conv_window_buffer.md
CONV_WINDOW_BUFFER -- requirements
Module: conv_window_buffer

Interface
REQ-001 Parameter IMG_W, default 28, meaning pixels per image row.
REQ-002 Parameter IMG_H, default 28, meaning rows per image.
REQ-003 Parameter PIX_W, default 24, meaning bits per pixel (3 channels x 8 bits, channel 0 in bits 7:0).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 pix_valid  input  1  pixel on pix_data accepted this cycle.
REQ-007 pix_data  input  PIX_W  raster-order pixel from the image input stage.
REQ-008 win_valid  output  1  win_data holds a complete 3x3 window this cycle.
REQ-009 win_data  output  9*PIX_W  window; slot k = 3*r+c at bits [k*PIX_W +: PIX_W], r=0 oldest row, c=0 oldest column.
REQ-010 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-011 Block SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) of the next pixel to accept.
REQ-012 On accept, col SHALL increment; at IMG_W-1 col SHALL wrap to 0 and row increment; at row IMG_H-1, col IMG_W-1 both SHALL wrap to 0.
REQ-013 Block SHALL hold two line buffers of IMG_W pixels each plus a 3x3 shift window; on accept the window SHALL shift one column left, taking the new column from (line buffer 0, line buffer 1, pix_data) at index col.
REQ-014 When pix_valid is low, counters, line buffers, window and outputs other than the pulses SHALL hold.
REQ-015 State machine SHALL have states FILL (row < 2) and RUN (row >= 2); FILL->RUN on accept of pixel (1, IMG_W-1); RUN->FILL on accept of pixel (IMG_H-1, IMG_W-1).
REQ-016 win_valid SHALL be high in the cycle after accepting a pixel with row >= 2 and col >= 2, otherwise low; latency exactly 1 cycle.
REQ-017 Slot 8 of win_data SHALL equal the pixel whose acceptance raised win_valid; slot 0 SHALL equal the pixel two rows up and two columns left.
REQ-018 Exactly (IMG_W-2)*(IMG_H-2) windows (676 at default) SHALL be produced per frame; windows SHALL never straddle a row boundary.
REQ-019 frame_done SHALL be high in the cycle after accepting pixel (IMG_H-1, IMG_W-1), coinciding with the final win_valid.
REQ-020 A pixel accepted in the same cycle as frame_done SHALL be treated as (0,0) of the next frame with no bubble.
REQ-021 No arithmetic on pixel data; data SHALL pass bit-exact.

Reset
REQ-022 On rst low: col=0, row=0, state FILL, win_valid=0, frame_done=0, win_data=0.
REQ-023 Line buffer contents need not be cleared; validity SHALL be gated solely by counters.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; the first pixel after release SHALL be (0,0).

Configuration
REQ-025 Macro WIN_COORD_EN: when defined, outputs win_row and win_col (each 5 bits, width of clog2 of IMG_H/IMG_W) SHALL give the window top-left coordinate, valid with win_valid, reset 0.
REQ-026 When WIN_COORD_EN is undefined, those ports SHALL not exist and behaviour is otherwise identical.

Verification
REQ-027 Reset, then 784 continuous pixels with pix_data = index -> first win_valid cycle after index 58; slots 0/4/8 = 0/29/58.
REQ-028 Same frame -> exactly 676 win_valid cycles; none after accepts with col 0 or 1; frame_done once, after index 783.
REQ-029 Same frame with pix_valid low every third cycle -> identical window sequence to REQ-027, outputs held during gaps.
REQ-030 Two back-to-back frames, second pixel value = index+1000 -> second frame first window slot 8 = 1058, slot 0 = 1000, no stale data.
REQ-031 Reset pulsed after index 400, then full frame -> 676 windows, first window slot 8 = 58.
REQ-032 WIN_COORD_EN defined, REQ-027 stimulus -> first window win_row=0, win_col=0; last window win_row=25, win_col=25.
